// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised VGA raster timing: H/V counters, registered syncs
//            with selectable polarity, blanking, line-end and frame-start.
//            Define VGA_FRAME_COUNT_EN to add an 8-bit frame_count output.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE         = 640,
    parameter int H_FP             = 16,
    parameter int H_SYNC           = 96,
    parameter int H_BP             = 48,
    parameter int V_ACTIVE         = 480,
    parameter int V_FP             = 10,
    parameter int V_SYNC           = 2,
    parameter int V_BP             = 33,
    parameter int CNT_W            = 16,
    parameter int SYNC_ACTIVE_HIGH = 0
) (
    input  logic             clk_25MHz,
    input  logic             reset,
    input  logic             pix_en,
    output logic [CNT_W-1:0] H_Count,
    output logic [CNT_W-1:0] V_Count,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_end,
    output logic             frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [7:0]       frame_count
`endif
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] c_H_LAST     = CNT_W'(c_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_V_LAST     = CNT_W'(c_V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] c_HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] c_VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] c_VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             c_SYNC_ON    = (SYNC_ACTIVE_HIGH != 0);

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_frame_start;

    logic             w_h_wrap;
    logic             w_v_wrap;
    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;
    logic             w_hsync_next;
    logic             w_vsync_next;

    // Syncs are decoded from the next counts so they line up with the counters.
    always_comb begin
        w_h_wrap     = (r_h >= c_H_LAST);
        w_v_wrap     = (r_v >= c_V_LAST);
        w_h_next     = w_h_wrap ? '0 : (r_h + 1'b1);
        w_v_next     = r_v;
        if (w_h_wrap) begin
            w_v_next = w_v_wrap ? '0 : (r_v + 1'b1);
        end
        w_hsync_next = ((w_h_next >= c_HS_START) && (w_h_next <= c_HS_END)) ? c_SYNC_ON : ~c_SYNC_ON;
        w_vsync_next = ((w_v_next >= c_VS_START) && (w_v_next <= c_VS_END)) ? c_SYNC_ON : ~c_SYNC_ON;
    end

    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            r_h           <= '0;
            r_v           <= '0;
            r_hsync       <= ~c_SYNC_ON;
            r_vsync       <= ~c_SYNC_ON;
            r_frame_start <= 1'b0;
        end else if (pix_en) begin
            r_h           <= w_h_next;
            r_v           <= w_v_next;
            r_hsync       <= w_hsync_next;
            r_vsync       <= w_vsync_next;
            r_frame_start <= w_h_wrap && w_v_wrap;
        end else begin
            r_frame_start <= 1'b0;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] r_frame_count;

    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            r_frame_count <= 8'd0;
        end else if (pix_en && w_h_wrap && w_v_wrap) begin
            r_frame_count <= r_frame_count + 8'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

    assign H_Count     = r_h;
    assign V_Count     = r_v;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;
    assign video_on    = (r_h < c_H_ACT) && (r_v < c_V_ACT);
    assign line_end    = (r_h == c_H_LAST);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Bench for vga_timing_gen: two configurations driven by shared
//            stimulus, compared each cycle against an arithmetic raster model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk;
    logic reset;
    logic pix_en;

    logic [15:0] a_h, a_v, b_h, b_v;
    logic a_hs, a_vs, a_vo, a_le, a_fs;
    logic b_hs, b_vs, b_vo, b_le, b_fs;
    logic [7:0] a_fc, b_fc;

    int     vectors;
    int     miscompares;
    longint n;
    bit     last_en;
    bit     valid;

    // Tiny raster, active-high syncs: 12 x 7 totals.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(0), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CNT_W(16), .SYNC_ACTIVE_HIGH(1)
    ) dut_a (
        .clk_25MHz(clk), .reset(reset), .pix_en(pix_en),
        .H_Count(a_h), .V_Count(a_v), .hsync(a_hs), .vsync(a_vs),
        .video_on(a_vo), .line_end(a_le), .frame_start(a_fs)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(a_fc)
`endif
    );

    // Default 800-pixel line, short 9-line frame, active-low syncs.
    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(1),
        .CNT_W(16), .SYNC_ACTIVE_HIGH(0)
    ) dut_b (
        .clk_25MHz(clk), .reset(reset), .pix_en(pix_en),
        .H_Count(b_h), .V_Count(b_v), .hsync(b_hs), .vsync(b_vs),
        .video_on(b_vo), .line_end(b_le), .frame_start(b_fs)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(b_fc)
`endif
    );

`ifndef VGA_FRAME_COUNT_EN
    assign a_fc = 8'd0;
    assign b_fc = 8'd0;
`endif

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (n=%0d, t=%0t)", nm, act, exp, n, $time);
        end
    endtask

    // Raster position is simply the number of enabled edges since reset.
    task automatic check_dut(input string nm,
                             input int ha, input int hfp, input int hs, input int hbp,
                             input int va, input int vfp, input int vs, input int vbp,
                             input bit hi,
                             input logic [15:0] h, input logic [15:0] v,
                             input logic hsy, input logic vsy, input logic vo,
                             input logic le, input logic fs, input logic [7:0] fc);
        longint ht, vt, eh, ev, frames;
        logic ehs, evs, efs;
        ht     = ha + hfp + hs + hbp;
        vt     = va + vfp + vs + vbp;
        eh     = n % ht;
        ev     = (n / ht) % vt;
        frames = n / (ht * vt);
        ehs    = (eh >= ha + hfp && eh < ha + hfp + hs) ? hi : !hi;
        evs    = (ev >= va + vfp && ev < va + vfp + vs) ? hi : !hi;
        efs    = last_en && (n > 0) && (n % (ht * vt) == 0);
        cmp({nm, ".H_Count"},     32'(h),   32'(eh));
        cmp({nm, ".V_Count"},     32'(v),   32'(ev));
        cmp({nm, ".hsync"},       32'(hsy), 32'(ehs));
        cmp({nm, ".vsync"},       32'(vsy), 32'(evs));
        cmp({nm, ".video_on"},    32'(vo),  32'(eh < ha && ev < va));
        cmp({nm, ".line_end"},    32'(le),  32'(eh == ht - 1));
        cmp({nm, ".frame_start"}, 32'(fs),  32'(efs));
`ifdef VGA_FRAME_COUNT_EN
        cmp({nm, ".frame_count"}, 32'(fc),  32'(frames % 256));
`else
        if (fc !== 8'd0 && frames < 0) cmp({nm, ".frame_count"}, 32'(fc), 32'd0);
`endif
    endtask

    always @(posedge clk) begin
        if (reset) begin
            n       = 0;
            last_en = 1'b0;
            valid   = 1'b1;
        end else if (pix_en) begin
            n       = n + 1;
            last_en = 1'b1;
        end else begin
            last_en = 1'b0;
        end
        #1;
        if (valid) begin
            check_dut("A", 8, 0, 2, 2, 4, 1, 1, 1, 1'b1,
                      a_h, a_v, a_hs, a_vs, a_vo, a_le, a_fs, a_fc);
            check_dut("B", 640, 16, 96, 48, 4, 2, 2, 1, 1'b0,
                      b_h, b_v, b_hs, b_vs, b_vo, b_le, b_fs, b_fc);
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        n           = 0;
        last_en     = 1'b0;
        valid       = 1'b0;
        reset       = 1'b1;
        pix_en      = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        cmp("rst.B.H", 32'(b_h), 32'd0);
        cmp("rst.B.V", 32'(b_v), 32'd0);
        cmp("rst.B.hsync", 32'(b_hs), 32'd1);
        cmp("rst.B.vsync", 32'(b_vs), 32'd1);
        cmp("rst.B.video_on", 32'(b_vo), 32'd1);
        cmp("rst.B.line_end", 32'(b_le), 32'd0);
        cmp("rst.B.frame_start", 32'(b_fs), 32'd0);
        cmp("rst.A.hsync", 32'(a_hs), 32'd0);
        cmp("rst.A.vsync", 32'(a_vs), 32'd0);
`ifdef VGA_FRAME_COUNT_EN
        cmp("rst.B.frame_count", 32'(b_fc), 32'd0);
`endif

        // Continuous enable through one full frame of B
        reset = 1'b0;
        repeat (656) @(negedge clk);
        cmp("n656.B.H", 32'(b_h), 32'd656);
        cmp("n656.B.hsync", 32'(b_hs), 32'd0);
        cmp("n656.B.video_on", 32'(b_vo), 32'd0);
        cmp("n656.A.H", 32'(a_h), 32'd8);
        cmp("n656.A.V", 32'(a_v), 32'd5);
        cmp("n656.A.hsync", 32'(a_hs), 32'd1);
        cmp("n656.A.vsync", 32'(a_vs), 32'd1);
        repeat (143) @(negedge clk);
        cmp("n799.B.line_end", 32'(b_le), 32'd1);
        cmp("n799.B.hsync", 32'(b_hs), 32'd1);
        repeat (6401) @(negedge clk);
        cmp("n7200.B.H", 32'(b_h), 32'd0);
        cmp("n7200.B.V", 32'(b_v), 32'd0);
        cmp("n7200.B.frame_start", 32'(b_fs), 32'd1);
        cmp("n7200.A.V", 32'(a_v), 32'd5);
`ifdef VGA_FRAME_COUNT_EN
        cmp("n7200.B.frame_count", 32'(b_fc), 32'd1);
`endif

        // Alternating enable
        repeat (300) begin
            pix_en = ~pix_en;
            @(negedge clk);
        end

        // Walk A to (0,0), then stall there for 20 clocks
        pix_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 100 && (n % 84) != 0; i++) @(negedge clk);
        cmp("stall.A.frame_start_in", 32'(a_fs), 32'd1);
        cmp("stall.A.H", 32'(a_h), 32'd0);
        pix_en = 1'b0;
        repeat (20) @(negedge clk);
        cmp("stall.A.frame_start_hold", 32'(a_fs), 32'd0);
        cmp("stall.A.V", 32'(a_v), 32'd0);
        pix_en = 1'b1;
        @(negedge clk);
        cmp("stall.A.H_after", 32'(a_h), 32'd1);

        // Random enable with occasional reset
        repeat (3000) begin
            pix_en = 1'($urandom_range(0, 1));
            reset  = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end

        // Mid-line reset with enable held high
        reset  = 1'b0;
        pix_en = 1'b1;
        repeat (2800) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmp("midrst.B.H", 32'(b_h), 32'd0);
        cmp("midrst.B.V", 32'(b_v), 32'd0);
        cmp("midrst.B.hsync", 32'(b_hs), 32'd1);
        cmp("midrst.B.frame_start", 32'(b_fs), 32'd0);
        cmp("midrst.A.hsync", 32'(a_hs), 32'd0);

        // Long run: A frame counter wraps after 256 frames
        repeat (21600) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
